// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - request/display bundle between requesters and the display arbiter
// Purpose: groups the four requesters' level requests and data bytes with the
// arbiter's grant and display-mux outputs.
// Signals:
//   req        [3:0]   req[k]=1: requester k wants the display (level, held)
//   req_data   [31:0]  requester k byte in req_data[8k+7:8k]
//   grant      [3:0]   one-hot owner, zero when idle or in the handover gap
//   disp_data  [7:0]   byte for the display mux
//   disp_blank         1 = force all anodes off
//   busy               1 while an owner holds the display or a gap runs
// Modports: master = requester side, slave = arbiter side.
interface seg_display_arbiter_if;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [7:0]  disp_data;
   logic        disp_blank;
   logic        busy;

   modport master (output req, req_data, input grant, disp_data, disp_blank, busy);
   modport slave  (input req, req_data, output grant, disp_data, disp_blank, busy);
endinterface

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner arbitration for the shared 4-digit display
// Purpose: hands the single seven-segment driver to one of four requesters at a
// time. An owner keeps the display at least MIN_HOLD cycles, is preempted after
// MAX_HOLD cycles if someone else waits, and every handover inserts GAP_CYCLES
// blanked cycles so the previous owner's digits do not ghost into the next.
// Ports:
//   clk   in   clock, all logic on posedge
//   rst   in   synchronous, active-high reset
//   disp  slave modport of seg_display_arbiter_if (req, req_data in;
//         grant, disp_data, disp_blank, busy out, all registered)
module seg_display_arbiter #(
   parameter int unsigned MIN_HOLD   = 65536,
   parameter int unsigned MAX_HOLD   = 1 << 22,
   parameter int unsigned GAP_CYCLES = 16,
   parameter logic [7:0]  IDLE_VALUE = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_display_arbiter_if.slave  disp
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [HW-1:0] MIN_LAST = HW'(MIN_HOLD - 1);
   localparam logic [HW-1:0] MAX_LAST = HW'(MAX_HOLD - 1);
   localparam logic [HW-1:0] MAX_SAT  = HW'(MAX_HOLD);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    last_q, last_d;     // current owner while in OWN, previous owner otherwise
   logic [HW-1:0] hold_q, hold_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]    grant_q, grant_d;
   logic [7:0]    data_q, data_d;
   logic          blank_q, blank_d;
   logic          busy_q, busy_d;

   logic          win_valid;
   logic [1:0]    win;
   logic [1:0]    idx;
   logic          others;
   logic          leave;
   logic          preempt;

   // Scan last+4 down to last+1 so the nearest set request after the
   // previous owner is the one left standing; last+4 is the previous owner
   // itself, which therefore only wins when nobody else asks.
   always_comb begin
      win_valid = 1'b0;
      win       = last_q;
      idx       = last_q;
      for (int i = 4; i >= 1; i--) begin
         idx = last_q + 2'(i);
         if (disp.req[idx]) begin
            win_valid = 1'b1;
            win       = idx;
         end
      end
   end

   assign others  = |(disp.req & ~grant_q);
   assign leave   = !disp.req[last_q] && (hold_q >= MIN_LAST);
   assign preempt = others && (hold_q >= MAX_LAST);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      grant_d = grant_q;
      data_d  = data_q;
      blank_d = blank_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE, GAP: begin
            grant_d = 4'b0000;
            data_d  = IDLE_VALUE;
            blank_d = 1'b1;
            busy_d  = (state_q == GAP);
            if (state_q == GAP && gap_q != GAP_LAST) begin
               gap_d = gap_q + 1'b1;
            end else if (win_valid) begin
               state_d = OWN;
               last_d  = win;
               hold_d  = '0;
               grant_d = 4'b0001 << win;
               blank_d = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         OWN: begin
            // Data follows the owner's live byte with one register of delay.
            data_d = disp.req_data[{last_q, 3'b000} +: 8];
            if (hold_q != MAX_SAT) begin
               hold_d = hold_q + 1'b1;
            end
            if (leave || preempt) begin
               grant_d = 4'b0000;
               data_d  = IDLE_VALUE;
               blank_d = 1'b1;
               if (others) begin
                  state_d = GAP;
                  gap_d   = '0;
                  busy_d  = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
            data_d  = IDLE_VALUE;
            blank_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         hold_q  <= '0;
         gap_q   <= '0;
         grant_q <= 4'b0000;
         data_q  <= IDLE_VALUE;
         blank_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         blank_q <= blank_d;
         busy_q  <= busy_d;
      end
   end

   assign disp.grant      = grant_q;
   assign disp.disp_data  = data_q;
   assign disp.disp_blank = blank_q;
   assign disp.busy       = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed bench for seg_display_arbiter
// Purpose: drives the arbiter with small timer parameters (MIN_HOLD=8,
// MAX_HOLD=32, GAP_CYCLES=4) through reset, single owner, round robin,
// preemption and mid-operation reset, with hand-computed expectations.
module tb_seg_display_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   seg_display_arbiter_if bus ();

   seg_display_arbiter #(
      .MIN_HOLD   (8),
      .MAX_HOLD   (32),
      .GAP_CYCLES (4),
      .IDLE_VALUE (8'h00)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .disp (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.req      = 4'b0000;
      bus.req_data = 32'h0;
      do_reset();
      n_cmp++; if (bus.grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
      n_cmp++; if (bus.disp_blank !== 1'b1) begin n_bad++; $display("FAIL reset_blank got %b want 1", bus.disp_blank); end
      n_cmp++; if (bus.disp_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", bus.disp_data); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_single_owner();
      bus.req_data = 32'h0000_00A5;
      bus.req      = 4'b0001;
      tick();
      n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", bus.grant); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.busy); end
      n_cmp++; if (bus.disp_data !== 8'h00) begin n_bad++; $display("FAIL single_data_latency got %h want 00", bus.disp_data); end
      tick();
      n_cmp++; if (bus.disp_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", bus.disp_data); end
      n_cmp++; if (bus.disp_blank !== 1'b0) begin n_bad++; $display("FAIL single_blank got %b want 0", bus.disp_blank); end
      // Owner has been in OWN for 2 cycles; it must keep the display for 8.
      bus.req = 4'b0000;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL min_hold_grant cycle %0d got %b want 0001", c, bus.grant); end
      end
      n_cmp++; if (bus.disp_data !== 8'hA5) begin n_bad++; $display("FAIL min_hold_data got %h want a5", bus.disp_data); end
      tick();
      n_cmp++; if (bus.grant !== 4'b0000) begin n_bad++; $display("FAIL release_grant got %b want 0000", bus.grant); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL release_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.disp_blank !== 1'b1) begin n_bad++; $display("FAIL release_blank got %b want 1", bus.disp_blank); end
      n_cmp++; if (bus.disp_data !== 8'h00) begin n_bad++; $display("FAIL release_data got %h want 00", bus.disp_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_grant;
      logic [7:0] exp_data;
      do_reset();
      bus.req_data = 32'h4433_2211;
      bus.req      = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         exp_grant = 4'b0001 << (k % 4);
         exp_data  = 8'((k % 4 + 1) * 17);
         for (int c = 0; c < 32; c++) begin
            n_cmp++; if (bus.grant !== exp_grant) begin n_bad++; $display("FAIL rr_grant owner %0d cycle %0d got %b want %b", k, c, bus.grant, exp_grant); end
            if (c >= 1) begin
               n_cmp++; if (bus.disp_data !== exp_data) begin n_bad++; $display("FAIL rr_data owner %0d cycle %0d got %h want %h", k, c, bus.disp_data, exp_data); end
            end
            tick();
         end
         if (k < 4) begin
            for (int g = 0; g < 4; g++) begin
               n_cmp++; if (bus.grant !== 4'b0000 || bus.disp_blank !== 1'b1 || bus.busy !== 1'b1)
                  begin n_bad++; $display("FAIL rr_gap after owner %0d cycle %0d got grant=%b blank=%b busy=%b want 0000/1/1", k, g, bus.grant, bus.disp_blank, bus.busy); end
               tick();
            end
         end
      end
   endtask

   task automatic test_preempt();
      do_reset();
      bus.req_data = 32'h0033_0000;
      bus.req      = 4'b0100;
      tick();
      n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL alone_grant got %b want 0100", bus.grant); end
      repeat (40) tick();
      n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL alone_past_max got %b want 0100", bus.grant); end
      n_cmp++; if (bus.disp_data !== 8'h33) begin n_bad++; $display("FAIL alone_data got %h want 33", bus.disp_data); end
      bus.req = 4'b0101;
      for (int g = 0; g < 4; g++) begin
         tick();
         n_cmp++; if (bus.grant !== 4'b0000 || bus.disp_blank !== 1'b1)
            begin n_bad++; $display("FAIL preempt_gap cycle %0d got grant=%b blank=%b want 0000/1", g, bus.grant, bus.disp_blank); end
      end
      tick();
      n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL preempt_next got %b want 0001", bus.grant); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req_data = 32'h4433_2211;
      bus.req      = 4'b1111;
      tick();
      repeat (33) tick();
      n_cmp++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_in_gap got grant=%b busy=%b want 0000/1", bus.grant, bus.busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.grant !== 4'b0000 || bus.disp_blank !== 1'b1 || bus.busy !== 1'b0 || bus.disp_data !== 8'h00)
         begin n_bad++; $display("FAIL gap_rst got grant=%b blank=%b busy=%b data=%h want 0000/1/0/00", bus.grant, bus.disp_blank, bus.busy, bus.disp_data); end
      tick();
      n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL gap_rst_first got %b want 0001", bus.grant); end
      repeat (3) tick();
      n_cmp++; if (bus.disp_data !== 8'h11) begin n_bad++; $display("FAIL mid_own_data got %h want 11", bus.disp_data); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.grant !== 4'b0000 || bus.disp_blank !== 1'b1 || bus.busy !== 1'b0 || bus.disp_data !== 8'h00)
         begin n_bad++; $display("FAIL own_rst got grant=%b blank=%b busy=%b data=%h want 0000/1/0/00", bus.grant, bus.disp_blank, bus.busy, bus.disp_data); end
      tick();
      n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL own_rst_first got %b want 0001", bus.grant); end
   endtask

   initial begin
      bus.req      = 4'b0000;
      bus.req_data = 32'h0;
      test_reset();
      test_single_owner();
      test_round_robin();
      test_preempt();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
